// File: rtl/noc_output_allocator.sv
// Per-output switch allocator for the 5-port wormhole router: round-robin head
// arbitration, wormhole lock until tail, and downstream credit accounting.

module noc_oa_port_dec (
  input  logic       i_req,
  input  logic [1:0] i_type,
  output logic       o_head,
  output logic       o_body,
  output logic       o_tail
);
  assign o_head = i_req && (i_type == 2'b01);
  assign o_body = i_req && (i_type == 2'b10);
  assign o_tail = i_req && (i_type == 2'b11);
endmodule

module noc_output_allocator #(
  parameter int NPORTS    = 5,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NPORTS-1:0]     i_req,
  input  logic [2*NPORTS-1:0]   i_in_type,
  input  logic                  i_credit_in,
  output logic [NPORTS-1:0]     o_grant,
  output logic [2:0]            o_sel,
  output logic                  o_out_valid,
  output logic                  o_locked,
  output logic [2:0]            o_owner,
  output logic [CNT_W-1:0]      o_credit_cnt,
  output logic                  o_cred_err,
  output logic                  o_proto_err
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_last, r_owner, r_sel;
  logic [NPORTS-1:0]   r_grant, w_grant_nxt;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_cred_err, r_proto_err;

  logic [NPORTS-1:0]   w_head, w_body, w_tail, w_bt;
  logic [2:0]          w_win;
  logic                w_found, w_send, w_proto, w_ovf, w_has_cred;

  for (genvar g = 0; g < NPORTS; g++) begin : g_dec
    noc_oa_port_dec u_dec (
      .i_req  (i_req[g]),
      .i_type (i_in_type[2*g +: 2]),
      .o_head (w_head[g]),
      .o_body (w_body[g]),
      .o_tail (w_tail[g])
    );
  end
  assign w_bt       = w_body | w_tail;
  assign w_has_cred = (r_cnt != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = '0;
    w_win       = r_owner;
    w_found     = 1'b0;
    w_send      = 1'b0;
    w_proto     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_proto = |w_bt;
        if ((|w_head) && w_has_cred) begin
          // scan starts just past the previous winner
          for (int k = 1; k <= NPORTS; k++) begin
            if (!w_found && w_head[3'((int'(r_last) + k) % NPORTS)]) begin
              w_found = 1'b1;
              w_win   = 3'((int'(r_last) + k) % NPORTS);
            end
          end
          w_send             = 1'b1;
          w_grant_nxt[w_win] = 1'b1;
          w_state_nxt        = S_LOCKED;
        end
      end
      S_LOCKED: begin
        w_proto = w_head[r_owner];
        if (w_bt[r_owner] && w_has_cred) begin
          w_send               = 1'b1;
          w_grant_nxt[r_owner] = 1'b1;
          if (w_tail[r_owner]) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // a returned credit with a full counter and nothing leaving is an overflow
  assign w_ovf = i_credit_in && !w_send && (r_cnt == CNT_W'(BUF_DEPTH));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!w_ovf) begin
      case ({w_send, i_credit_in})
        2'b10:   w_cnt_nxt = r_cnt - CNT_W'(1);
        2'b01:   w_cnt_nxt = r_cnt + CNT_W'(1);
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 3'(NPORTS - 1);
      r_owner     <= '0;
      r_sel       <= '0;
      r_grant     <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= CNT_W'(BUF_DEPTH);
      r_cred_err  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_out_valid <= w_send;
      r_cnt       <= w_cnt_nxt;
      if (w_send) r_sel <= w_win;
      if (w_send && r_state == S_IDLE) begin
        r_owner <= w_win;
        r_last  <= w_win;
      end
      if (w_ovf)   r_cred_err  <= 1'b1;
      if (w_proto) r_proto_err <= 1'b1;
    end
  end

  assign o_grant      = r_grant;
  assign o_sel        = r_sel;
  assign o_out_valid  = r_out_valid;
  assign o_locked     = (r_state == S_LOCKED);
  assign o_owner      = r_owner;
  assign o_credit_cnt = r_cnt;
  assign o_cred_err   = r_cred_err;
  assign o_proto_err  = r_proto_err;

endmodule
